// File: rtl/fios_bram_pkg.sv
// Shared types, constants and helpers for the FIOS BRAM responder.
// Holds the FSM encoding and the parameter sanity checks used at elaboration.
package fios_bram_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;
    localparam int MIN_RD_LAT = 1;
    localparam int MAX_RD_LAT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN
    } state_t;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 1) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fios_bram_responder_bram.sv
// True dual-port byte-enabled memory: port A is the master port with a
// configurable read pipeline, port B is the 1-cycle internal port.
module bram_tdp_model
    import fios_bram_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 1,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_en,
    input  logic [BYTE_LANES-1:0] i_a_we,
    input  logic [AW-1:0]         i_a_addr,
    input  logic [WORD_W-1:0]     i_a_din,
    output logic [WORD_W-1:0]     o_a_dout,
    input  logic                  i_b_en,
    input  logic [BYTE_LANES-1:0] i_b_we,
    input  logic [AW-1:0]         i_b_addr,
    input  logic [WORD_W-1:0]     i_b_din,
    output logic [WORD_W-1:0]     o_b_dout
);

    logic [WORD_W-1:0]       r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_a_vld;
    logic [WORD_W-1:0]       r_a_pipe [READ_LATENCY];
    logic [WORD_W-1:0]       r_a_hold;
    logic [WORD_W-1:0]       r_b_dout;
    logic                    w_a_rd;
    logic                    w_b_rd;

    assign w_a_rd = i_a_en && (i_a_we == '0);
    assign w_b_rd = i_b_en && (i_b_we == '0);

    // Host lanes are written first so master lanes win on a shared word.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BYTE_LANES; b++) begin
            if (i_b_en && i_b_we[b])
                r_mem[i_b_addr][8*b +: 8] <= i_b_din[8*b +: 8];
            if (i_a_en && i_a_we[b])
                r_mem[i_a_addr][8*b +: 8] <= i_a_din[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_vld  <= '0;
            r_a_hold <= '0;
            r_b_dout <= '0;
            for (int i = 0; i < READ_LATENCY; i++)
                r_a_pipe[i] <= '0;
        end else begin
            r_a_vld[0] <= w_a_rd;
            if (w_a_rd)
                r_a_pipe[0] <= r_mem[i_a_addr];
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_a_vld[i]  <= r_a_vld[i-1];
                r_a_pipe[i] <= r_a_pipe[i-1];
            end
            r_a_hold <= o_a_dout;
            if (w_b_rd)
                r_b_dout <= r_mem[i_b_addr];
        end
    end

    assign o_a_dout = r_a_vld[READ_LATENCY-1] ? r_a_pipe[READ_LATENCY-1]
                                              : r_a_hold;
    assign o_b_dout = r_b_dout;

endmodule

// File: rtl/fios_bram_responder.sv
// BRAM slave for the FIOS multiplier master port, bridged to a host stream:
// load operands, pulse start, wait for done, drain results through a skid buffer.
module fios_bram_responder
    import fios_bram_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int READ_LATENCY = 1,
    parameter int N_IN_WORDS   = 48,
    parameter int RES_BASE     = 48,
    parameter int RES_WORDS    = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              BRAM_en_i,
    input  logic [3:0]        BRAM_we_i,
    input  logic [31:0]       BRAM_addr_i,
    input  logic [31:0]       BRAM_din_i,
    output logic [31:0]       BRAM_dout_o,
    input  logic [31:0]       load_data_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    output logic [31:0]       res_data_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              start_o,
    input  logic              done_i,
    output logic              busy_o,
    output logic              addr_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam bit P_OK = is_pow2(DEPTH)
        && (READ_LATENCY >= MIN_RD_LAT) && (READ_LATENCY <= MAX_RD_LAT)
        && (N_IN_WORDS >= 1) && (N_IN_WORDS <= DEPTH)
        && (RES_WORDS >= 1) && (RES_BASE >= 0)
        && (RES_BASE + RES_WORDS <= DEPTH);

    if (!P_OK) begin : g_param_check
        $error("fios_bram_responder: illegal parameter set");
    end

    state_t            r_state;
    logic [CW-1:0]     r_ld_cnt;
    logic [CW-1:0]     r_iss_cnt;
    logic [CW-1:0]     r_out_cnt;
    logic              r_load_ready;
    logic              r_start;
    logic              r_busy;
    logic              r_addr_err;
    logic              r_inflight;
    logic [WORD_W-1:0] r_buf [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_fcnt;

    logic [29:0]       w_idx;
    logic              w_legal;
    logic              w_bad;
    logic              w_ld_hs;
    logic              w_pop;
    logic              w_issue;
    logic              w_b_en;
    logic [3:0]        w_b_we;
    logic [AW-1:0]     w_b_addr;
    logic [WORD_W-1:0] w_b_dout;

    assign w_idx   = word_index(BRAM_addr_i);
    assign w_legal = (BRAM_addr_i[1:0] == 2'b00) && ({2'b00, w_idx} < DEPTH);
    assign w_bad   = BRAM_en_i && !w_legal;
    assign w_ld_hs = load_valid_i && r_load_ready;
    assign w_pop   = res_valid_o && res_ready_i;

    // A pop this cycle frees a slot, so issue can keep pace at 1 word/cycle.
    assign w_issue = (r_state == S_DRAIN)
        && (r_iss_cnt < CW'(RES_WORDS))
        && ((({1'b0, r_fcnt} + {2'b00, r_inflight}) < 3'd2) || w_pop);

    assign w_b_en   = w_ld_hs || w_issue;
    assign w_b_we   = w_ld_hs ? 4'hF : 4'h0;
    assign w_b_addr = w_ld_hs ? r_ld_cnt[AW-1:0]
                              : AW'(RES_BASE) + r_iss_cnt[AW-1:0];

    bram_tdp_model #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_mem (
        .i_clk    (clock_i),
        .i_rst    (reset_i),
        .i_a_en   (BRAM_en_i && w_legal),
        .i_a_we   (BRAM_we_i),
        .i_a_addr (w_idx[AW-1:0]),
        .i_a_din  (BRAM_din_i),
        .o_a_dout (BRAM_dout_o),
        .i_b_en   (w_b_en),
        .i_b_we   (w_b_we),
        .i_b_addr (w_b_addr),
        .i_b_din  (load_data_i),
        .o_b_dout (w_b_dout)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_ld_cnt     <= '0;
            r_iss_cnt    <= '0;
            r_out_cnt    <= '0;
            r_load_ready <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_load_ready <= 1'b1;
                    if (w_ld_hs) begin
                        r_busy <= 1'b1;
                        if (N_IN_WORDS == 1) begin
                            r_state      <= S_START;
                            r_start      <= 1'b1;
                            r_load_ready <= 1'b0;
                        end else begin
                            r_state  <= S_LOAD;
                            r_ld_cnt <= CW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (w_ld_hs) begin
                        if (r_ld_cnt == CW'(N_IN_WORDS - 1)) begin
                            r_state      <= S_START;
                            r_start      <= 1'b1;
                            r_load_ready <= 1'b0;
                            r_ld_cnt     <= '0;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + CW'(1);
                        end
                    end
                end
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (done_i) begin
                        r_state   <= S_DRAIN;
                        r_iss_cnt <= '0;
                        r_out_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_issue)
                        r_iss_cnt <= r_iss_cnt + CW'(1);
                    if (w_pop) begin
                        r_out_cnt <= r_out_cnt + CW'(1);
                        if (r_out_cnt == CW'(RES_WORDS - 1)) begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_load_ready <= 1'b1;
                            r_iss_cnt    <= '0;
                            r_out_cnt    <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_bad)
                r_addr_err <= 1'b1;
            else if ((r_state == S_IDLE) && w_ld_hs)
                r_addr_err <= 1'b0;
        end
    end

    // Two-entry skid buffer fed by the 1-cycle internal read port.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_inflight <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fcnt     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_buf[r_wptr] <= w_b_dout;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_fcnt <= r_fcnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign res_valid_o  = (r_fcnt != 2'd0);
    assign res_data_o   = r_buf[r_rptr];
    assign load_ready_o = r_load_ready;
    assign start_o      = r_start;
    assign busy_o       = r_busy;
    assign addr_err_o   = r_addr_err;

endmodule

// File: tb/tb_fios_bram_responder.sv
// Directed self-checking bench for fios_bram_responder (READ_LATENCY=2).
// Each task drives one scenario and checks against hand-computed values.
module tb_fios_bram_responder;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        BRAM_en_i;
    logic [3:0]  BRAM_we_i;
    logic [31:0] BRAM_addr_i;
    logic [31:0] BRAM_din_i;
    logic [31:0] BRAM_dout_o;
    logic [31:0] load_data_i;
    logic        load_valid_i;
    logic        load_ready_o;
    logic [31:0] res_data_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        start_o;
    logic        done_i;
    logic        busy_o;
    logic        addr_err_o;

    int n_cmp = 0;
    int n_err = 0;

    fios_bram_responder #(
        .DEPTH        (64),
        .READ_LATENCY (RL),
        .N_IN_WORDS   (48),
        .RES_BASE     (48),
        .RES_WORDS    (16)
    ) dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .BRAM_en_i    (BRAM_en_i),
        .BRAM_we_i    (BRAM_we_i),
        .BRAM_addr_i  (BRAM_addr_i),
        .BRAM_din_i   (BRAM_din_i),
        .BRAM_dout_o  (BRAM_dout_o),
        .load_data_i  (load_data_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .res_data_o   (res_data_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .start_o      (start_o),
        .done_i       (done_i),
        .busy_o       (busy_o),
        .addr_err_o   (addr_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mread(input logic [31:0] a, output logic [31:0] d);
        BRAM_en_i   = 1'b1;
        BRAM_we_i   = 4'h0;
        BRAM_addr_i = a;
        tick();
        BRAM_en_i = 1'b0;
        repeat (RL - 1) tick();
        d = BRAM_dout_o;
    endtask

    task automatic mwrite(input logic [31:0] a, input logic [3:0] we,
                          input logic [31:0] d);
        BRAM_en_i   = 1'b1;
        BRAM_we_i   = we;
        BRAM_addr_i = a;
        BRAM_din_i  = d;
        tick();
        BRAM_en_i = 1'b0;
        BRAM_we_i = 4'h0;
    endtask

    task automatic do_load(input logic [31:0] base, input int nw,
                           input bit collide, output int rdy);
        int acc = 0;
        int guard = 0;
        rdy = 0;
        load_valid_i = 1'b1;
        load_data_i  = base;
        while (acc < nw && guard < 200) begin
            if (collide && acc == 10) begin
                BRAM_en_i   = 1'b1;
                BRAM_we_i   = 4'b1100;
                BRAM_addr_i = 32'h28;
                BRAM_din_i  = 32'hDEAD_0000;
            end else begin
                BRAM_en_i = 1'b0;
                BRAM_we_i = 4'h0;
            end
            if (load_ready_o) begin
                rdy++;
                acc++;
            end
            tick();
            guard++;
            load_data_i = base + acc;
        end
        load_valid_i = 1'b0;
        BRAM_en_i    = 1'b0;
        BRAM_we_i    = 4'h0;
        n_cmp++;
        if (acc != nw) begin
            n_err++;
            $display("FAIL load_timeout: accepted %0d want %0d", acc, nw);
        end
    endtask

    task automatic write_results(input logic [31:0] base);
        for (int j = 0; j < 16; j++)
            mwrite((48 + j) * 4, 4'hF, base + j);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({load_ready_o, busy_o, start_o, res_valid_o, addr_err_o,
             BRAM_dout_o, res_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b busy=%b start=%b valid=%b err=%b",
                     load_ready_o, busy_o, start_o, res_valid_o, addr_err_o);
        end
        reset_i = 1'b0;
        tick();
        n_cmp++;
        if (load_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: ready=%b busy=%b want 1 0",
                     load_ready_o, busy_o);
        end
    endtask

    task automatic test_load();
        int rdy;
        do_load(32'h100, 48, 1'b1, rdy);
        n_cmp++;
        if (rdy != 48) begin
            n_err++;
            $display("FAIL ready_cycles: got %0d want 48", rdy);
        end
        n_cmp++;
        if (start_o !== 1'b1 || load_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL start_state: start=%b ready=%b busy=%b want 1 0 1",
                     start_o, load_ready_o, busy_o);
        end
        tick();
        n_cmp++;
        if (start_o !== 1'b0 || busy_o !== 1'b1 || load_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_pulse_end: start=%b busy=%b ready=%b want 0 1 0",
                     start_o, busy_o, load_ready_o);
        end
    endtask

    task automatic test_master_read();
        BRAM_en_i   = 1'b1;
        BRAM_we_i   = 4'h0;
        BRAM_addr_i = 32'h0C;
        tick();
        BRAM_en_i = 1'b0;
        n_cmp++;
        if (BRAM_dout_o !== 32'h0) begin
            n_err++;
            $display("FAIL read_early: got %h want 00000000", BRAM_dout_o);
        end
        tick();
        n_cmp++;
        if (BRAM_dout_o !== 32'h103) begin
            n_err++;
            $display("FAIL read_lat2: got %h want 00000103", BRAM_dout_o);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        mread(32'h28, d);
        n_cmp++;
        if (d !== 32'hDEAD_010A) begin
            n_err++;
            $display("FAIL collision: got %h want dead010a", d);
        end
    endtask

    task automatic test_master_write();
        logic [31:0] d;
        BRAM_en_i   = 1'b1;
        BRAM_we_i   = 4'h0;
        BRAM_addr_i = 32'h14;
        tick();
        BRAM_we_i  = 4'b0011;
        BRAM_din_i = 32'h0001_ABCD;
        tick();
        BRAM_en_i = 1'b0;
        BRAM_we_i = 4'h0;
        n_cmp++;
        if (BRAM_dout_o !== 32'h105) begin
            n_err++;
            $display("FAIL read_before_write: got %h want 00000105", BRAM_dout_o);
        end
        tick();
        mread(32'h14, d);
        n_cmp++;
        if (d !== 32'h0000_ABCD) begin
            n_err++;
            $display("FAIL byte_write: got %h want 0000abcd", d);
        end
    endtask

    task automatic test_addr_err();
        logic [31:0] d;
        n_cmp++;
        if (addr_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear_initial: got %b want 0", addr_err_o);
        end
        mwrite(32'h0E, 4'hF, 32'hBADB_AD00);
        n_cmp++;
        if (addr_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_set_misaligned: got %b want 1", addr_err_o);
        end
        mwrite(32'h400, 4'hF, 32'hBADB_AD01);
        mwrite(32'h102, 4'hF, 32'hBADB_AD02);
        mread(32'h0C, d);
        n_cmp++;
        if (d !== 32'h103) begin
            n_err++;
            $display("FAIL word3_unchanged: got %h want 00000103", d);
        end
        mread(32'h00, d);
        n_cmp++;
        if (d !== 32'h100) begin
            n_err++;
            $display("FAIL word0_unchanged: got %h want 00000100", d);
        end
        BRAM_en_i   = 1'b1;
        BRAM_we_i   = 4'h0;
        BRAM_addr_i = 32'h40C;
        tick();
        BRAM_en_i = 1'b0;
        repeat (RL + 1) tick();
        n_cmp++;
        if (BRAM_dout_o !== 32'h100) begin
            n_err++;
            $display("FAIL illegal_read_hold: got %h want 00000100", BRAM_dout_o);
        end
        n_cmp++;
        if (addr_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %b want 1", addr_err_o);
        end
    endtask

    task automatic test_drain();
        int w = 0;
        write_results(32'hA0);
        n_cmp++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL run_state: valid=%b busy=%b want 0 1", res_valid_o, busy_o);
        end
        res_ready_i = 1'b1;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        while (!res_valid_o && w < 2) begin
            tick();
            w++;
        end
        n_cmp++;
        if (res_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL first_valid: valid=%b after %0d cycles want 1", res_valid_o, w);
        end
        for (int n = 0; n < 16; n++) begin
            n_cmp++;
            if (res_valid_o !== 1'b1 || res_data_o !== 32'hA0 + n) begin
                n_err++;
                $display("FAIL drain_word%0d: valid=%b data=%h want 1 %h",
                         n, res_valid_o, res_data_o, 32'hA0 + n);
            end
            tick();
        end
        n_cmp++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || load_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end: valid=%b busy=%b ready=%b want 0 0 1",
                     res_valid_o, busy_o, load_ready_o);
        end
        n_cmp++;
        if (addr_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_held_idle: got %b want 1", addr_err_o);
        end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        tick();
        n_cmp++;
        if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_idle: busy=%b valid=%b want 0 0", busy_o, res_valid_o);
        end
    endtask

    task automatic test_stall_drain();
        int rdy;
        int n = 0;
        int guard = 0;
        bit stalled = 1'b0;
        bit r;
        res_ready_i = 1'b0;
        do_load(32'h200, 48, 1'b0, rdy);
        n_cmp++;
        if (addr_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared_on_load: got %b want 0", addr_err_o);
        end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL done_in_start: valid=%b busy=%b want 0 1", res_valid_o, busy_o);
        end
        write_results(32'hC0);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        while (n < 16 && guard < 400) begin
            if (stalled) begin
                n_cmp++;
                if (res_valid_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_valid_drop: word %0d", n);
                end
            end
            if (res_valid_o) begin
                n_cmp++;
                if (res_data_o !== 32'hC0 + n) begin
                    n_err++;
                    $display("FAIL stall_word%0d: got %h want %h",
                             n, res_data_o, 32'hC0 + n);
                end
            end
            r = 1'($urandom_range(0, 1));
            res_ready_i = r;
            stalled = res_valid_o && !r;
            if (res_valid_o && r)
                n++;
            tick();
            guard++;
        end
        res_ready_i = 1'b0;
        n_cmp++;
        if (n != 16) begin
            n_err++;
            $display("FAIL stall_timeout: got %0d words want 16", n);
        end
        n_cmp++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_end: valid=%b busy=%b want 0 0", res_valid_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        int rdy;
        int w = 0;
        logic [31:0] d;
        do_load(32'h300, 20, 1'b0, rdy);
        #2 reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({load_ready_o, busy_o, start_o, res_valid_o, addr_err_o,
             BRAM_dout_o, res_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_load: ready=%b busy=%b dout=%h",
                     load_ready_o, busy_o, BRAM_dout_o);
        end
        tick();
        reset_i = 1'b0;
        tick();
        do_load(32'h400, 48, 1'b0, rdy);
        n_cmp++;
        if (rdy != 48 || start_o !== 1'b1) begin
            n_err++;
            $display("FAIL reload: ready_cycles=%0d start=%b want 48 1", rdy, start_o);
        end
        tick();
        mread(32'h00, d);
        n_cmp++;
        if (d !== 32'h400) begin
            n_err++;
            $display("FAIL reload_word0: got %h want 00000400", d);
        end
        mread(32'hBC, d);
        n_cmp++;
        if (d !== 32'h42F) begin
            n_err++;
            $display("FAIL reload_word47: got %h want 0000042f", d);
        end
        write_results(32'hE0);
        res_ready_i = 1'b1;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        while (!res_valid_o && w < 4) begin
            tick();
            w++;
        end
        repeat (3) tick();
        n_cmp++;
        if (res_valid_o !== 1'b1 || res_data_o !== 32'hE3) begin
            n_err++;
            $display("FAIL mid_drain: valid=%b data=%h want 1 000000e3",
                     res_valid_o, res_data_o);
        end
        #2 reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({load_ready_o, busy_o, start_o, res_valid_o, addr_err_o,
             BRAM_dout_o, res_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_drain: valid=%b busy=%b data=%h dout=%h",
                     res_valid_o, busy_o, res_data_o, BRAM_dout_o);
        end
        res_ready_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        n_cmp++;
        if (load_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_mid_reset: ready=%b busy=%b want 1 0",
                     load_ready_o, busy_o);
        end
    endtask

    initial begin
        reset_i      = 1'b1;
        BRAM_en_i    = 1'b0;
        BRAM_we_i    = 4'h0;
        BRAM_addr_i  = 32'h0;
        BRAM_din_i   = 32'h0;
        load_data_i  = 32'h0;
        load_valid_i = 1'b0;
        res_ready_i  = 1'b0;
        done_i       = 1'b0;
        test_reset();
        test_load();
        test_master_read();
        test_collision();
        test_master_write();
        test_addr_err();
        test_drain();
        test_stall_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fios_bram_responder.md
Name: fios_bram_responder

Overview:
- BRAM slave that answers the FIOS multiplier's master BRAM interface (en/we/byte-addr/din/dout) and bridges it to a host stream.
- Host streams operand words in. Block pulses start to the multiplier and waits for done, then streams result words out.
- Replaces the processor-side BRAM controller in simulation and standalone (no-PS) builds.

Parameters:
- DEPTH, 64: memory depth in 32-bit words; power of two.
- READ_LATENCY, 1: master-port read latency in cycles; legal range 1..3.
- N_IN_WORDS, 48: words loaded at word addresses 0..N_IN_WORDS-1 before start; must be 1..DEPTH.
- RES_BASE, 48: word address of the first result word.
- RES_WORDS, 16: number of result words drained; RES_BASE+RES_WORDS must be <= DEPTH.

Ports:
- clock_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- BRAM_en_i  in  1  master access enable
- BRAM_we_i  in  4  master byte write enables
- BRAM_addr_i  in  32  master byte address
- BRAM_din_i  in  32  master write data
- BRAM_dout_o  out  32  master read data
- load_data_i  in  32  host operand word
- load_valid_i  in  1  host word valid
- load_ready_o  out  1  block accepts host word
- res_data_o  out  32  result word
- res_valid_o  out  1  result word valid
- res_ready_i  in  1  host accepts result word
- start_o  out  1  one-cycle start pulse to multiplier
- done_i  in  1  multiplier completion
- busy_o  out  1  high outside IDLE
- addr_err_o  out  1  sticky illegal master access

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. Load/drain counters are cleared. All outputs go to 0. Memory contents are not cleared.
- FSM states: IDLE, LOAD, START, RUN, DRAIN.
- IDLE:
  - load_ready_o=1.
  - A load handshake writes word 0, clears addr_err_o, and moves to LOAD.
  - If N_IN_WORDS==1, it moves to START instead.
- LOAD:
  - load_ready_o=1.
  - The k-th handshake writes word address k.
  - After word N_IN_WORDS-1 is accepted, the FSM moves to START.
  - load_valid_i low stalls the FSM with no timeout.
- START: start_o=1 for exactly one cycle, then RUN. load_ready_o=0.
- RUN:
  - Waits for done_i; done_i=1 moves to DRAIN.
  - done_i is ignored in all other states.
  - A done_i in the START cycle is ignored.
- DRAIN:
  - Reads RES_BASE..RES_BASE+RES_WORDS-1 in order.
  - First res_valid_o rises no later than 2 cycles after DRAIN entry.
  - res_data_o is stable while res_valid_o=1 and res_ready_i=0.
  - Sustains 1 word/cycle when res_ready_i is held high; a 2-entry skid buffer is required.
  - After the last handshake, the FSM returns to IDLE with res_valid_o=0.
- Master port (served in every state):
  - Word index = BRAM_addr_i[31:2].
  - Access is legal only if BRAM_addr_i[1:0]==0 and index<DEPTH.
  - An illegal access with BRAM_en_i=1 is ignored (no write, dout holds) and sets addr_err_o. The flag stays set until the next IDLE→LOAD transition.
  - Write: byte lane b is updated when BRAM_en_i and BRAM_we_i[b].
  - Read: when BRAM_en_i=1 and we=0, BRAM_dout_o presents the word READ_LATENCY cycles later.
  - BRAM_dout_o holds its last value when no read completes.
  - Read-during-write on the master port returns old data (read-first).
- Port collision (same word written by host-side load and master in one cycle): master byte lanes win, unmasked lanes take host data.
- Internal read vs master write to the same word in one cycle: internal read returns old data.
- Counters are sized to clog2(DEPTH)+1. No wrap is possible given the parameter constraints, which are checked at elaboration.

Decomposition:
- Package fios_bram_pkg:
  - FSM state enum.
  - Constants WORD_W=32 and BYTE_LANES=4.
  - Function for word-index extraction.
  - Elaboration-check constants.
- Sub-module bram_tdp_model:
  - True dual-port, byte-enabled memory.
  - Port A: parameterised READ_LATENCY pipeline, read-first.
  - Port B: 1-cycle latency, internal use.
  - Holds the collision rule.
- The top level holds the FSM, counters, skid buffer and error flag.

Test Plan:
- Stream 48 words 0x100+k with valid held high -> load_ready_o high for 48 cycles; start_o high exactly 1 cycle; busy_o=1.
- Master reads addr 0x0C with READ_LATENCY=2 -> BRAM_dout_o=0x103 exactly 2 cycles after en.
- Master writes 0x0001ABCD with we=4'b0011 to word 5 (was 0x105), then reads word 5 -> 0x0000ABCD. A same-cycle read of word 5 returns 0x105.
- Master access at addr 0x102 and at addr 0x400 (DEPTH=64) -> memory unchanged; addr_err_o=1 and stays set until the next load start.
- Master writes 0xA0+j to words 48..63, then pulse done_i -> 16 result words 0xA0..0xAF with res_ready_i high, one per cycle. Random res_ready_i stalls keep data stable, with no loss or duplication.
- Assert reset_i mid-LOAD (word 20) and mid-DRAIN -> all outputs 0 immediately. A fresh load then restarts at word address 0.
